bcd_display_feeder: RTL and testbench
=====================================

BCD_DISPLAY_FEEDER -- requirements
Module: bcd_display_feeder

Interface
REQ-001 The block SHALL have ports: clk  input  1  single clock, all logic on rising edge.
REQ-002 reset  input  1  SHALL be asynchronous, active-low (0 = reset asserted).
REQ-003 in_value  input  16  unsigned binary result from the calculator core.
REQ-004 in_valid  input  1  in_value valid this cycle.
REQ-005 in_ready  output  1  high only when the block can accept a new value.
REQ-006 hex_mode  input  1  request raw hex display; used only when HEX_BYPASS_EN is defined (REQ-025).
REQ-007 displayed_number  output  16  four packed BCD digits; [15:12] is the leftmost digit; feeds the seven-segment display stage.
REQ-008 display_sel  output  1  level, high once any result has been published; downstream samples it only at its refresh wrap.
REQ-009 overflow  output  1  last published value exceeded 9999.
REQ-010 conv_done  output  1  one-cycle pulse on each publish.

Function
REQ-011 The FSM SHALL have states IDLE, SHIFT and DONE; in_ready = (state == IDLE).
REQ-012 Accept SHALL occur on an edge where in_valid && in_ready; the block latches in_value, clears a 20-bit BCD accumulator and a 5-bit iteration counter, and enters SHIFT.
REQ-013 In SHIFT, each cycle SHALL add 3 to every BCD nibble that is >= 5, then shift {bcd, bin} left by 1; exactly 16 iterations, then go to DONE.
REQ-014 In DONE, the block SHALL update displayed_number, overflow and display_sel, pulse conv_done, and return to IDLE.
REQ-015 Latency: for an accept at edge N, outputs SHALL update at edge N+17, with in_ready high again after edge N+17.
REQ-016 Overflow SHALL be true iff accumulator[19:16] != 0 (value > 9999); then displayed_number = 16'hEEEE and overflow = 1; otherwise displayed_number = accumulator[15:0] and overflow = 0.
REQ-017 Leading zeros SHALL be shown (value 7 -> 16'h0007).
REQ-018 in_valid while in SHIFT or DONE SHALL be ignored, with no queuing; the producer holds it until in_ready.
REQ-019 displayed_number and overflow SHALL stay stable between publishes.
REQ-020 display_sel, once set, SHALL remain 1 until reset.
REQ-021 conv_done SHALL be high for exactly one cycle per accepted value.

Reset
REQ-022 On reset = 0, the block SHALL immediately (asynchronously) force: state IDLE, displayed_number 16'h0000, display_sel 0, overflow 0, conv_done 0, and clear the accumulator and counter.
REQ-023 Reset mid-conversion SHALL discard the conversion, publish nothing, and leave no conv_done pulse.
REQ-024 After release, in_ready SHALL be 1 on the first cycle.

Configuration
REQ-025 With macro HEX_BYPASS_EN defined: an accept with hex_mode = 1 SHALL go IDLE -> DONE directly, publish in_value unchanged with overflow = 0, and give latency 1 (update at edge N+1).
REQ-026 Without HEX_BYPASS_EN: hex_mode SHALL be ignored and every value is BCD-converted.

Structure
REQ-027 A shared package SHALL hold: the state encoding type; constants DATA_W = 16, BCD_W = 20, N_ITER = 16, OVF_PATTERN = 16'hEEEE.
REQ-028 Sub-module bcd_add3 SHALL be the combinational per-nibble (>= 5 ? +3) adjust, instantiated five times.

Verification
REQ-029 in_value = 0 accepted at edge N -> displayed_number = 16'h0000, overflow 0, conv_done pulse at N+17, display_sel 0 -> 1.
REQ-030 in_value = 1234 -> 16'h1234; in_value = 9999 -> 16'h9999, overflow 0.
REQ-031 in_value = 10000, then 65535 -> 16'hEEEE, overflow 1 each time; next 42 -> 16'h0042, overflow 0.
REQ-032 Second in_valid pulsed at N+5 during a conversion -> ignored, only one conv_done, in_ready low N+1..N+17.
REQ-033 Reset asserted at N+8 -> outputs zero immediately, no conv_done, in_ready 1 after release; a new value of 5 then yields 16'h0005.
REQ-034 HEX_BYPASS_EN defined, hex_mode = 1, in_value = 16'hBEEF -> displayed_number = 16'hBEEF at N+1, overflow 0; undefined -> 16'hEEEE (48879 > 9999).

Source files
------------

// File: rtl/bcd_display_feeder_pkg.sv
// Shared types and constants for the BCD display feeder.
// The optional raw-hex bypass is enabled with `define HEX_BYPASS_EN.
package bcd_display_feeder_pkg;

    localparam int DATA_W = 16;
    localparam int BCD_W  = 20;
    localparam int N_ITER = 16;
    localparam int CNT_W  = 5;
    localparam logic [DATA_W-1:0] OVF_PATTERN = 16'hEEEE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble adjust: add 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_add3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/bcd_display_feeder.sv
// Converts a 16-bit binary result to four packed BCD digits for the display.
// Define HEX_BYPASS_EN to let hex_mode publish the raw value in one cycle.
module bcd_display_feeder
    import bcd_display_feeder_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_value,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              hex_mode,
    output logic [DATA_W-1:0] displayed_number,
    output logic              display_sel,
    output logic              overflow,
    output logic              conv_done
);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [DATA_W-1:0]         r_bin;
    logic [BCD_W-1:0]          r_acc;
    logic [CNT_W-1:0]          r_cnt;
    logic [BCD_W-1:0]          w_adj;
    logic [BCD_W+DATA_W-1:0]   w_shift;
    logic                      w_go_hex;

    generate
        for (genvar gi = 0; gi < BCD_W / 4; gi++) begin : g_adj
            bcd_add3 u_add3 (
                .i_nib (r_acc[gi*4 +: 4]),
                .o_nib (w_adj[gi*4 +: 4])
            );
        end
    endgenerate

    assign w_shift  = {w_adj, r_bin} << 1;
    assign in_ready = (r_state == IDLE);

`ifdef HEX_BYPASS_EN
    logic r_hex;
    assign w_go_hex = hex_mode;
`else
    logic w_unused_hex;
    assign w_unused_hex = hex_mode;
    assign w_go_hex     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_next = w_go_hex ? DONE : SHIFT;
            SHIFT:   if (r_cnt == CNT_W'(N_ITER - 1)) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bin            <= '0;
            r_acc            <= '0;
            r_cnt            <= '0;
            displayed_number <= '0;
            display_sel      <= 1'b0;
            overflow         <= 1'b0;
            conv_done        <= 1'b0;
`ifdef HEX_BYPASS_EN
            r_hex            <= 1'b0;
`endif
        end else begin
            conv_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_bin <= in_value;
                        r_acc <= '0;
                        r_cnt <= '0;
`ifdef HEX_BYPASS_EN
                        r_hex <= hex_mode;
`endif
                    end
                end
                SHIFT: begin
                    r_acc <= w_shift[BCD_W+DATA_W-1:DATA_W];
                    r_bin <= w_shift[DATA_W-1:0];
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                DONE: begin
                    display_sel <= 1'b1;
                    conv_done   <= 1'b1;
`ifdef HEX_BYPASS_EN
                    if (r_hex) begin
                        displayed_number <= r_bin;
                        overflow         <= 1'b0;
                    end else
`endif
                    // A non-zero fifth digit means the value is above 9999.
                    if (r_acc[BCD_W-1:DATA_W] != '0) begin
                        displayed_number <= OVF_PATTERN;
                        overflow         <= 1'b1;
                    end else begin
                        displayed_number <= r_acc[DATA_W-1:0];
                        overflow         <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_display_feeder.sv
// Scoreboard bench for bcd_display_feeder: stimulus pushes expected publishes,
// a monitor pops and checks them on each conv_done pulse.
module tb_bcd_display_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_value;
    logic        in_valid;
    logic        in_ready;
    logic        hex_mode;
    logic [15:0] displayed_number;
    logic        display_sel;
    logic        overflow;
    logic        conv_done;

    typedef struct {
        logic [15:0] num;
        logic        ovf;
        int          at;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_mon;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [15:0] prev_num = 16'h0000;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_display_feeder dut (
        .clk              (clk),
        .reset            (reset),
        .in_value         (in_value),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .hex_mode         (hex_mode),
        .displayed_number (displayed_number),
        .display_sel      (display_sel),
        .overflow         (overflow),
        .conv_done        (conv_done)
    );

    task automatic check1(input string name, input logic act, input logic req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic send(input logic [15:0] v, input logic hx, input logic [15:0] en,
                        input logic eo, input int lat);
        int w;
        @(negedge clk);
        in_value = v;
        in_valid = 1'b1;
        hex_mode = hx;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
        end
        sb.push_back('{en, eo, cyc + 1 + lat});
        $display("[TB] send value=%h hex=%b expect number=%h ovf=%b at cycle %0d",
                 v, hx, en, eo, cyc + 1 + lat);
        @(negedge clk);
        in_valid = 1'b0;
        hex_mode = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d publishes missing, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int n;
        reset    = 1'b0;
        in_value = 16'h0000;
        in_valid = 1'b0;
        hex_mode = 1'b0;
        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (reset) begin
                        if (conv_done) begin
                            tests++;
                            if (sb.size() == 0) begin
                                fails++;
                                $display("FAIL unexpected_conv_done: got pulse at cycle %0d, required none", cyc);
                            end else begin
                                e_mon = sb.pop_front();
                                if (displayed_number !== e_mon.num || overflow !== e_mon.ovf ||
                                    display_sel !== 1'b1 || cyc != e_mon.at) begin
                                    fails++;
                                    $display("FAIL publish: got number=%h ovf=%b sel=%b cycle=%0d, required number=%h ovf=%b sel=1 cycle=%0d",
                                             displayed_number, overflow, display_sel, cyc,
                                             e_mon.num, e_mon.ovf, e_mon.at);
                                end else begin
                                    $display("[TB] publish number=%h ovf=%b cycle=%0d ok",
                                             displayed_number, overflow, cyc);
                                end
                            end
                        end else if (displayed_number !== prev_num) begin
                            tests++;
                            fails++;
                            $display("FAIL stable: got %h without conv_done, required %h", displayed_number, prev_num);
                        end
                    end
                    prev_num = displayed_number;
                end
            end
            begin : stimulus
                // Asynchronous reset state, before any clock edge matters.
                #2;
                check16("reset_number", displayed_number, 16'h0000);
                check1("reset_sel", display_sel, 1'b0);
                check1("reset_ovf", overflow, 1'b0);
                check1("reset_done", conv_done, 1'b0);
                @(negedge clk);
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                check1("ready_after_reset", in_ready, 1'b1);

                send(16'd0,     1'b0, 16'h0000, 1'b0, 17);
                drain();
                send(16'd1234,  1'b0, 16'h1234, 1'b0, 17);
                send(16'd9999,  1'b0, 16'h9999, 1'b0, 17);
                send(16'd10000, 1'b0, 16'hEEEE, 1'b1, 17);
                send(16'd65535, 1'b0, 16'hEEEE, 1'b1, 17);
                send(16'd42,    1'b0, 16'h0042, 1'b0, 17);
                drain();

                // Busy window: a second request mid-conversion must be ignored.
                send(16'd7, 1'b0, 16'h0007, 1'b0, 17);
                n = cyc;
                for (int k = 1; k <= 17; k++) begin
                    @(negedge clk);
                    if (k == 4) begin
                        in_value = 16'd77;
                        in_valid = 1'b1;
                    end
                    if (k == 5) in_valid = 1'b0;
                    check1($sformatf("ready_N+%0d", k), in_ready, (k == 17));
                end
                drain();

                // Reset in the middle of a conversion.
                send(16'd4321, 1'b0, 16'h4321, 1'b0, 17);
                n = cyc;
                while (cyc < n + 8) @(posedge clk);
                #1;
                reset = 1'b0;
                sb.delete();
                #1;
                check16("midreset_number", displayed_number, 16'h0000);
                check1("midreset_sel", display_sel, 1'b0);
                check1("midreset_done", conv_done, 1'b0);
                check1("midreset_ready", in_ready, 1'b1);
                @(negedge clk);
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                check1("ready_after_midreset", in_ready, 1'b1);
                repeat (20) @(negedge clk);
                send(16'd5, 1'b0, 16'h0005, 1'b0, 17);
                drain();

`ifdef HEX_BYPASS_EN
                send(16'hBEEF, 1'b1, 16'hBEEF, 1'b0, 1);
`else
                send(16'hBEEF, 1'b1, 16'hEEEE, 1'b1, 17);
`endif
                drain();
                repeat (3) @(negedge clk);
            end
        join_any
        disable fork;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
